// File: rtl/volcado_regs.sv
// volcado_regs: dumps register bank entries 0..15 over a UART-style serial line.
// One frame per entry: start bit, 8 data bits LSB first, stop bit. The frame
// begins only once cts is seen high in LEER.
module volcado_regs #(
    parameter int CLKS_POR_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cts,
    input  logic [7:0] rd,
    output logic [3:0] ra,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {REPOSO, LEER, INICIO, DATOS, PARADA} estado_t;

    localparam logic [7:0] CNT_MAX = 8'(CLKS_POR_BIT - 1);

    estado_t    estado, estado_n;
    logic [3:0] ra_n;
    logic [7:0] sh, sh_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] bidx, bidx_n;
    logic       tx_n, busy_n, done_n;
    logic       fin_bit;

    assign fin_bit = (cnt == CNT_MAX);

    // State and registered outputs; tx is a flop so the line never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
            ra     <= 4'd0;
            sh     <= 8'd0;
            cnt    <= 8'd0;
            bidx   <= 3'd0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            estado <= estado_n;
            ra     <= ra_n;
            sh     <= sh_n;
            cnt    <= cnt_n;
            bidx   <= bidx_n;
            tx     <= tx_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next state; tx_n is the level the line takes in the state being entered
    always_comb begin
        estado_n = estado;
        ra_n     = ra;
        sh_n     = sh;
        cnt_n    = cnt;
        bidx_n   = bidx;
        tx_n     = tx;
        busy_n   = busy;
        done_n   = 1'b0;
        case (estado)
            REPOSO: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    ra_n     = 4'd0;
                    busy_n   = 1'b1;
                    estado_n = LEER;
                end
            end
            LEER: begin
                tx_n = 1'b1;
                if (cts) begin
                    // rd is captured only here; later bank changes cannot leak in
                    sh_n     = rd;
                    cnt_n    = 8'd0;
                    bidx_n   = 3'd0;
                    tx_n     = 1'b0;
                    estado_n = INICIO;
                end
            end
            INICIO: begin
                if (fin_bit) begin
                    cnt_n    = 8'd0;
                    tx_n     = sh[0];
                    estado_n = DATOS;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DATOS: begin
                if (fin_bit) begin
                    cnt_n = 8'd0;
                    if (bidx == 3'd7) begin
                        tx_n     = 1'b1;
                        estado_n = PARADA;
                    end else begin
                        bidx_n = bidx + 3'd1;
                        sh_n   = {1'b0, sh[7:1]};
                        tx_n   = sh[1];
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PARADA: begin
                tx_n = 1'b1;
                if (fin_bit) begin
                    cnt_n = 8'd0;
                    if (ra == 4'd15) begin
                        // ra stays at 15; no wrap
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        estado_n = REPOSO;
                    end else begin
                        ra_n     = ra + 4'd1;
                        estado_n = LEER;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                estado_n = REPOSO;
                tx_n     = 1'b1;
                busy_n   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_volcado_regs.sv
// Bench for volcado_regs: two instances (CLKS_POR_BIT 4 and 1), a frame
// decoder on the selected tx line, and a queue of expected bytes.
module tb_volcado_regs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start4 = 1'b0, start1 = 1'b0;
    logic       cts = 1'b1;
    logic [3:0] ra4, ra1;
    logic       tx4, tx1, busy4, busy1, done4, done1;
    logic [7:0] bank [16];
    logic [7:0] rd4, rd1;

    assign rd4 = bank[ra4];
    assign rd1 = bank[ra1];

    volcado_regs #(.CLKS_POR_BIT(4)) u4 (
        .clk(clk), .reset(rst_n), .start(start4), .cts(cts), .rd(rd4),
        .ra(ra4), .tx(tx4), .busy(busy4), .done(done4)
    );
    volcado_regs #(.CLKS_POR_BIT(1)) u1 (
        .clk(clk), .reset(rst_n), .start(start1), .cts(1'b1), .rd(rd1),
        .ra(ra1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests = 0, fails = 0;
    logic [7:0] expq [$];
    bit         sel = 1'b0;
    bit         chk_period = 1'b1;
    int         last_fall = -1;

    logic       mtx, mdone, mbusy;
    logic [3:0] mra;
    assign mtx   = sel ? tx1   : tx4;
    assign mdone = sel ? done1 : done4;
    assign mbusy = sel ? busy1 : busy4;
    assign mra   = sel ? ra1   : ra4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_bank();
        for (int k = 0; k < 16; k++) bank[k] = (k == 0) ? 8'h00 : 8'(8'h10 + k);
    endtask

    task automatic push_all();
        for (int k = 0; k < 16; k++) expq.push_back(bank[k]);
    endtask

    // Pulse start on the selected instance; returns cycle stamp of the accepting edge
    task automatic go(output int t_acc);
        last_fall = -1;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        t_acc = cyc;
        chk("busy_after_start", {31'd0, mbusy}, 1);
    endtask

    task automatic wait_done(input int t_acc, input int exp_len);
        int g;
        g = 0;
        while (mdone !== 1'b1 && g < exp_len + 100) begin
            @(negedge clk);
            g++;
        end
        chk("done_time", cyc - t_acc, exp_len);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, mdone}, 0);
        chk("busy_cleared", {31'd0, mbusy}, 0);
        chk("ra_held_15", {28'd0, mra}, 15);
        chk("queue_drained", expq.size(), 0);
    endtask

    // Frame decoder: checks every cycle of each level, then pops the expected byte
    initial begin : mon
        int cpb;
        logic [7:0] data;
        logic [7:0] e;
        bit bad, ab;
        forever begin
            @(negedge clk);
            if (mtx === 1'b0 && rst_n) begin
                cpb = sel ? 1 : 4;
                if (chk_period && last_fall >= 0)
                    chk("frame_period", cyc - last_fall, 1 + 10 * cpb);
                last_fall = cyc;
                bad = 1'b0;
                ab = 1'b0;
                data = 8'd0;
                for (int i = 1; i < cpb; i++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    if (mtx !== 1'b0) bad = 1'b1;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < cpb; i++) begin
                        @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                        if (i == 0) data[b] = mtx;
                        else if (mtx !== data[b]) bad = 1'b1;
                    end
                end
                for (int i = 0; i < cpb; i++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    if (mtx !== 1'b1) bad = 1'b1;
                end
                if (ab) begin
                    last_fall = -1;
                end else if (expq.size() == 0) begin
                    chk("frame_expected", expq.size(), 1);
                end else begin
                    e = expq.pop_front();
                    chk("frame_data", {24'd0, data}, {24'd0, e});
                    chk("frame_shape", {31'd0, bad}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        int g;
        bit saw;
        load_bank();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx4", {31'd0, tx4}, 1);
        chk("rst_busy4", {31'd0, busy4}, 0);
        chk("rst_done4", {31'd0, done4}, 0);
        chk("rst_ra4", {28'd0, ra4}, 0);
        chk("rst_tx1", {31'd0, tx1}, 1);
        chk("rst_busy1", {31'd0, busy1}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Plain dump: 00,11..1F, done 656 cycles after the accepting edge
        push_all();
        go(t);
        wait_done(t, 656);

        // Reg 3 = A5, bank changes after capture, start re-pulsed in frame 7
        bank[3] = 8'hA5;
        push_all();
        go(t);
        while (cyc < t + 130) @(negedge clk);
        bank[3] = 8'hFF;
        while (cyc < t + 7 * 41 + 10) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("busy_during_repulse", {31'd0, busy4}, 1);
        wait_done(t, 656);
        load_bank();

        // cts held low 20 cycles while in LEER at ra=5
        chk_period = 1'b0;
        push_all();
        go(t);
        g = 0;
        while (ra4 !== 4'd5 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("reach_ra5", {28'd0, ra4}, 5);
        cts = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || ra4 !== 4'd5) saw = 1'b1;
        end
        chk("cts_hold_idle", {31'd0, saw}, 0);
        cts = 1'b1;
        @(negedge clk);
        chk("cts_resume_start_bit", {31'd0, tx4}, 0);
        wait_done(t, 676);
        chk_period = 1'b1;

        // Reset during DATOS of frame 9, then restart on the first edge after release
        push_all();
        go(t);
        while (cyc < t + 380) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx4}, 1);
        chk("abort_busy", {31'd0, busy4}, 0);
        chk("abort_ra", {28'd0, ra4}, 0);
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done4 !== 1'b0) saw = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw}, 0);
        expq.delete();
        push_all();
        last_fall = -1;
        start4 = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        t = cyc;
        chk("busy_after_release_start", {31'd0, busy4}, 1);
        chk("ra_after_release_start", {28'd0, ra4}, 0);
        wait_done(t, 656);

        // CLKS_POR_BIT=1 instance: 11-cycle frames, 176-cycle dump
        sel = 1'b1;
        push_all();
        go(t);
        wait_done(t, 176);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/volcado_regs.md
VOLCADO_REGS -- requirements
Module: volcado_regs

Interface
REQ-001 The block SHALL have one parameter: CLKS_POR_BIT, default 4, clock cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-004 The block SHALL have the port start, input, 1 bit: request a full dump of register bank entries 0..15.
REQ-005 The block SHALL have the port cts, input, 1 bit: clear-to-send from the receiving end; 1 = a frame may begin.
REQ-006 The block SHALL have the port rd, input, 8 bits: data from a combinational register-bank read port addressed by ra.
REQ-007 The block SHALL have the port ra, output, 4 bits: register-bank read address.
REQ-008 The block SHALL have the port tx, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have the port busy, output, 1 bit: 1 from dump acceptance until the return to REPOSO.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse on dump completion.

Function
REQ-011 The FSM SHALL have exactly these states: REPOSO, LEER, INICIO, DATOS, PARADA.
REQ-012 In REPOSO, start=1 at a rising edge SHALL load ra=0 and move to LEER; busy goes to 1 on that edge.
REQ-013 While busy=1, start SHALL be ignored and SHALL NOT restart or extend the dump.
REQ-014 In LEER, with cts=1 at the edge, the block SHALL capture rd[ra] into an 8-bit shift register and move to INICIO; with cts=0 it SHALL hold in LEER indefinitely, tx=1.
REQ-015 LEER SHALL last exactly 1 cycle when cts=1; rd is sampled only on that edge, and later changes of rd SHALL NOT affect the frame.
REQ-016 INICIO SHALL drive tx=0 for exactly CLKS_POR_BIT cycles.
REQ-017 DATOS SHALL drive the 8 captured bits LSB first, each for exactly CLKS_POR_BIT cycles (8*CLKS_POR_BIT cycles total).
REQ-018 PARADA SHALL drive tx=1 for exactly CLKS_POR_BIT cycles.
REQ-019 At the end of PARADA with ra<15, the block SHALL increment ra and move to LEER.
REQ-020 At the end of PARADA with ra=15, the block SHALL move to REPOSO, set busy=0, pulse done=1 for exactly one cycle, and leave ra at 15 (no wrap to 0).
REQ-021 With cts held at 1, each register frame SHALL take 1+10*CLKS_POR_BIT cycles; a full dump SHALL take 16*(1+10*CLKS_POR_BIT) cycles.
REQ-022 The per-bit cycle counter SHALL be wide enough for 255 with no overflow; the bit index SHALL count 0..7 and reset at each INICIO.
REQ-023 cts SHALL be examined only in LEER; deasserting cts mid-frame SHALL NOT alter that frame.
REQ-024 tx SHALL be registered (glitch-free) and SHALL be 1 in REPOSO and LEER.
REQ-025 Register 0 SHALL be sent like any other entry, with its value taken from rd (the bank returns 0).

Reset
REQ-026 While reset=0: state=REPOSO, ra=0, tx=1, busy=0, done=0, shift register=0, counters=0, asynchronously and independently of clk.
REQ-027 A reset asserted mid-frame SHALL abort the dump immediately (tx=1 at once) with no done pulse; after release, a new start SHALL begin again at ra=0.
REQ-028 start present on the first edge after reset release SHALL be accepted normally.

Verification (CLKS_POR_BIT=4, cts=1 unless stated)
REQ-029 Bench case: bank with reg k = 8'h10+k, start pulse -> 16 frames decoded as 00,11,12,...,1F; each frame 41 cycles; done pulses once, 656 cycles after the accepting edge.
REQ-030 Bench case: rd=8'hA5 at reg 3 -> tx sequence 0,1,0,1,0,0,1,0,1, each level 4 cycles.
REQ-031 Bench case: cts=0 held 20 cycles while in LEER at ra=5 -> tx stays 1, ra=5 throughout, then frame 5 begins 1 cycle after cts returns to 1.
REQ-032 Bench case: start re-pulsed during frame 7 -> no effect; total duration and done timing unchanged.
REQ-033 Bench case: reset=0 during DATOS of frame 9 -> tx=1, busy=0, ra=0 immediately; no done; a new start dumps from reg 0.
REQ-034 Bench case: CLKS_POR_BIT=1 -> frame = 11 cycles, dump = 176 cycles, data identical to REQ-029.
